// File: rtl/mem_access_initiator.sv
`timescale 1ns/1ps
// mem_access_initiator
// Initiator side of the N-core data-memory handshake. Accepts one LD/ST request
// with a per-core enable mask, latches it and issues a one-cycle MRead/MWrite to
// the memory controller. It then waits for a rising edge on MReady, captures the
// read data of the enabled lanes and reports done, or err on timeout or on an
// illegal request.
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   ld_req, st_req          one-cycle request pulses from the control unit
//   core_en/addr/wdata      per-lane mask, addresses and store data
//   busy                    high from accept until return to IDLE
//   done, err, req_dropped  one-cycle status pulses
//   load_data               captured read data, lane-packed
//   MRead, MWrite           one-cycle strobes to the controller
//   en, addr, data          latched request, stable from ISSUE through DONE
//   MReady, q               completion and read data from the controller
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request
// ISSUE   | MRead/MWrite strobe high, timeout counter loaded
// WAIT    | waiting for a rising edge on MReady, counting down to timeout
// CAPTURE | loading q into load_data for the enabled lanes (loads only)
// DONE    | done pulse, back to IDLE
module mem_access_initiator #(
  parameter int N_CORES = 4,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_req,
  input  logic                  st_req,
  input  logic [N_CORES-1:0]    core_en,
  input  logic [N_CORES*AW-1:0] core_addr,
  input  logic [N_CORES*DW-1:0] core_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  req_dropped,
  output logic [N_CORES*DW-1:0] load_data,
  output logic                  MRead,
  output logic                  MWrite,
  output logic [N_CORES-1:0]    en,
  output logic [N_CORES*AW-1:0] addr,
  output logic [N_CORES*DW-1:0] data,
  input  logic                  MReady,
  input  logic [N_CORES*DW-1:0] q
);

  // The timer counts down to zero from TIMEOUT-2. With the registered err
  // this places the err pulse exactly TIMEOUT cycles after the strobe cycle.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMR_LOAD = CW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t        state;
  logic          op_ld;
  logic          mr_q;
  logic [CW-1:0] tmr;
  logic          mr_rise;

  // Only a fresh edge completes; a level left high by an earlier access does not.
  assign mr_rise = MReady & ~mr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      op_ld       <= 1'b0;
      mr_q        <= 1'b0;
      tmr         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      req_dropped <= 1'b0;
      load_data   <= '0;
      MRead       <= 1'b0;
      MWrite      <= 1'b0;
      en          <= '0;
      addr        <= '0;
      data        <= '0;
    end else begin
      mr_q        <= MReady;
      done        <= 1'b0;
      err         <= 1'b0;
      req_dropped <= 1'b0;
      MRead       <= 1'b0;
      MWrite      <= 1'b0;

      if ((state != S_IDLE) && (ld_req || st_req))
        req_dropped <= 1'b1;

      case (state)
        S_IDLE: begin
          if (ld_req && st_req) begin
            err <= 1'b1;
          end else if (ld_req || st_req) begin
            if (core_en == '0) begin
              // Nothing to access: complete at once without touching memory.
              done <= 1'b1;
            end else begin
              en     <= core_en;
              addr   <= core_addr;
              data   <= core_wdata;
              op_ld  <= ld_req;
              MRead  <= ld_req;
              MWrite <= st_req;
              busy   <= 1'b1;
              state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          tmr   <= TMR_LOAD;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mr_rise) begin
            if (op_ld) begin
              state <= S_CAPTURE;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else if (tmr == '0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_CAPTURE: begin
          for (int i = 0; i < N_CORES; i++) begin
            if (en[i])
              load_data[i*DW +: DW] <= q[i*DW +: DW];
          end
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
`timescale 1ns/1ps
module tb_mem_access_initiator;

  localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3, K_DROP = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic        busy;
    logic [63:0] ld;
    logic [3:0]  en;
    logic [63:0] addr;
    logic [63:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ld_req, st_req;
  logic [3:0]  core_en;
  logic [63:0] core_addr, core_wdata;
  logic        busy, done, err, req_dropped;
  logic [63:0] load_data;
  logic        MRead, MWrite;
  logic [3:0]  en;
  logic [63:0] addr, data;
  logic        MReady;
  logic [63:0] q;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t stale;

  logic [15:0] mem [0:255];
  int   ctl_k = 1;
  int   ctl_hold = 2;
  logic ctl_stub = 1'b0;
  int   rise_at = -1;
  int   fall_at = -1;
  logic [63:0] ld_model;

  mem_access_initiator dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .st_req(st_req),
    .core_en(core_en), .core_addr(core_addr), .core_wdata(core_wdata),
    .busy(busy), .done(done), .err(err), .req_dropped(req_dropped),
    .load_data(load_data),
    .MRead(MRead), .MWrite(MWrite),
    .en(en), .addr(addr), .data(data),
    .MReady(MReady), .q(q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  function automatic string kname(input int k);
    case (k)
      K_RD:    return "MRead";
      K_WR:    return "MWrite";
      K_DONE:  return "done";
      K_ERR:   return "err";
      K_DROP:  return "req_dropped";
      default: return "none";
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_ev(input int kind);
    exp_t e;
    logic ok;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s: seen at cycle %0d, none expected", kname(kind), cyc);
      return;
    end
    e = sb.pop_front();
    ok = (e.kind == kind) && (e.cyc == cyc);
    case (kind)
      K_RD:   ok = ok && (en === e.en) && (addr === e.addr) && (MWrite === 1'b0);
      K_WR:   ok = ok && (en === e.en) && (addr === e.addr) && (data === e.data) && (MRead === 1'b0);
      K_DONE,
      K_ERR:  ok = ok && (load_data === e.ld) && (busy === e.busy);
      default: ;
    endcase
    if (!ok) begin
      n_bad++;
      $display("FAIL event_%s: got %s@%0d ld=%h en=%b addr=%h data=%h busy=%b; want %s@%0d ld=%h en=%b addr=%h data=%h busy=%b",
               kname(e.kind), kname(kind), cyc, load_data, en, addr, data, busy,
               kname(e.kind), e.cyc, e.ld, e.en, e.addr, e.data, e.busy);
    end
  endtask

  // Scoreboard monitor: every strobe or status pulse must match the next expectation.
  always @(negedge clk) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        stale = sb.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_%s: expected at cycle %0d, not seen by %0d", kname(stale.kind), stale.cyc, cyc);
      end
      if (MRead)       check_ev(K_RD);
      if (MWrite)      check_ev(K_WR);
      if (done)        check_ev(K_DONE);
      if (err)         check_ev(K_ERR);
      if (req_dropped) check_ev(K_DROP);
    end
  end

  // Controller model: memory behind the handshake, MReady rises ctl_k cycles after the strobe.
  initial begin
    MReady = 1'b0;
    q = 64'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    mem[11] = 16'h0014;
    mem[5]  = 16'h0777;
    mem[30] = 16'h5A5A;
    forever begin
      @(negedge clk);
      if (!reset && (MRead || MWrite)) begin
        if (MWrite)
          for (int i = 0; i < 4; i++)
            if (en[i]) mem[addr[i*16 +: 8]] = data[i*16 +: 16];
        if (!ctl_stub) begin
          rise_at = cyc + ctl_k;
          fall_at = rise_at + ctl_hold;
        end
      end
      @(posedge clk);
      #1;
      if (cyc == rise_at) begin
        MReady = 1'b1;
        for (int i = 0; i < 4; i++) q[i*16 +: 16] = mem[addr[i*16 +: 8]];
      end
      if (cyc == fall_at) MReady = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input logic l, input logic s, input logic [3:0] m,
                     input logic [63:0] a, input logic [63:0] w, output int c);
    @(posedge clk);
    #1;
    ld_req = l; st_req = s; core_en = m; core_addr = a; core_wdata = w;
    @(posedge clk);
    #1;
    c = cyc;
    ld_req = 1'b0; st_req = 1'b0;
  endtask

  task automatic push(input int kind, input int c, input logic b, input logic [63:0] ldv,
                      input logic [3:0] m, input logic [63:0] a, input logic [63:0] w);
    exp_t e;
    e.kind = kind; e.cyc = c; e.busy = b; e.ld = ldv; e.en = m; e.addr = a; e.data = w;
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk($sformatf("%s_busy", tag),   64'(busy), 64'h0);
    chk($sformatf("%s_done", tag),   64'(done), 64'h0);
    chk($sformatf("%s_err", tag),    64'(err), 64'h0);
    chk($sformatf("%s_drop", tag),   64'(req_dropped), 64'h0);
    chk($sformatf("%s_mread", tag),  64'(MRead), 64'h0);
    chk($sformatf("%s_mwrite", tag), 64'(MWrite), 64'h0);
    chk($sformatf("%s_ld", tag),     load_data, 64'h0);
    chk($sformatf("%s_en", tag),     64'(en), 64'h0);
    chk($sformatf("%s_addr", tag),   addr, 64'h0);
    chk($sformatf("%s_data", tag),   data, 64'h0);
  endtask

  initial begin
    int c, c2;
    logic [63:0] a1, a2, w2, a3, a6, w6, a7, a8;
    a1 = {16'd3, 16'd2, 16'd11, 16'd1};
    a2 = {16'd23, 16'd22, 16'd21, 16'd20};
    w2 = {16'd24, 16'd55, 16'd20, 16'd9};
    a3 = {16'd3, 16'd2, 16'd1, 16'd0};
    a6 = {16'd0, 16'd0, 16'd0, 16'd40};
    w6 = {16'd0, 16'd0, 16'd0, 16'hBEEF};
    a7 = {16'd3, 16'd2, 16'd1, 16'd5};
    a8 = {16'd30, 16'd0, 16'd0, 16'd0};
    reset = 1'b1; ld_req = 1'b0; st_req = 1'b0;
    core_en = 4'h0; core_addr = 64'h0; core_wdata = 64'h0;
    ld_model = 64'h0;
    tick(3);
    chk_zero("reset");
    reset = 1'b0;
    tick(2);

    // Single-lane load, MReady edge 3 cycles after the strobe.
    ctl_stub = 1'b0; ctl_k = 3; ctl_hold = 2;
    req(1'b1, 1'b0, 4'b0010, a1, 64'h0, c);
    push(K_RD, c, 1'b1, 64'h0, 4'b0010, a1, 64'h0);
    ld_model = 64'h0000_0000_0014_0000;
    push(K_DONE, c + 5, 1'b1, ld_model, 4'h0, 64'h0, 64'h0);
    tick(8);

    // Four-lane store, edge 1 cycle after the strobe.
    ctl_k = 1;
    req(1'b0, 1'b1, 4'b1111, a2, w2, c);
    push(K_WR, c, 1'b1, 64'h0, 4'b1111, a2, w2);
    push(K_DONE, c + 2, 1'b1, ld_model, 4'h0, 64'h0, 64'h0);
    tick(5);
    chk("mem20", 64'(mem[20]), 64'd9);
    chk("mem21", 64'(mem[21]), 64'd20);
    chk("mem22", 64'(mem[22]), 64'd55);
    chk("mem23", 64'(mem[23]), 64'd24);

    // Load lanes 0 and 2; lane 1 keeps its earlier value.
    req(1'b1, 1'b0, 4'b0101, a2, 64'h0, c);
    push(K_RD, c, 1'b1, 64'h0, 4'b0101, a2, 64'h0);
    ld_model = {16'd0, 16'd55, 16'h0014, 16'd9};
    push(K_DONE, c + 3, 1'b1, ld_model, 4'h0, 64'h0, 64'h0);
    tick(6);

    // Timeout with MReady held low.
    ctl_stub = 1'b1;
    req(1'b1, 1'b0, 4'b1111, a3, 64'h0, c);
    push(K_RD, c, 1'b1, 64'h0, 4'b1111, a3, 64'h0);
    push(K_ERR, c + 64, 1'b0, ld_model, 4'h0, 64'h0, 64'h0);
    tick(63);
    chk("timeout_busy_before", 64'(busy), 64'h1);
    tick(1);
    chk("timeout_busy_after", 64'(busy), 64'h0);
    tick(4);

    // Illegal double request, then empty mask.
    req(1'b1, 1'b1, 4'b0011, a3, 64'h0, c);
    push(K_ERR, c, 1'b0, ld_model, 4'h0, 64'h0, 64'h0);
    tick(3);
    req(1'b1, 1'b0, 4'b0000, a3, 64'h0, c);
    push(K_DONE, c, 1'b0, ld_model, 4'h0, 64'h0, 64'h0);
    tick(3);

    // MReady left high from a store must not complete the following load.
    ctl_stub = 1'b0; ctl_k = 1; ctl_hold = 70;
    req(1'b0, 1'b1, 4'b0001, a6, w6, c);
    push(K_WR, c, 1'b1, 64'h0, 4'b0001, a6, w6);
    push(K_DONE, c + 2, 1'b1, ld_model, 4'h0, 64'h0, 64'h0);
    tick(3);
    ctl_stub = 1'b1;
    req(1'b1, 1'b0, 4'b0001, a6, 64'h0, c2);
    push(K_RD, c2, 1'b1, 64'h0, 4'b0001, a6, 64'h0);
    push(K_ERR, c2 + 64, 1'b0, ld_model, 4'h0, 64'h0, 64'h0);
    tick(72);
    chk("leftover_mready_low", 64'(MReady), 64'h0);

    // Second request during WAIT is dropped; only one strobe.
    ctl_stub = 1'b0; ctl_k = 6; ctl_hold = 2;
    req(1'b1, 1'b0, 4'b0001, a7, 64'h0, c);
    push(K_RD, c, 1'b1, 64'h0, 4'b0001, a7, 64'h0);
    push(K_DROP, c + 3, 1'b1, 64'h0, 4'h0, 64'h0, 64'h0);
    ld_model[15:0] = 16'h0777;
    push(K_DONE, c + 8, 1'b1, ld_model, 4'h0, 64'h0, 64'h0);
    tick(2);
    ld_req = 1'b1; core_en = 4'b1111;
    tick(1);
    ld_req = 1'b0;
    tick(8);

    // Reset in WAIT clears everything at once; the next request runs normally.
    ctl_stub = 1'b1;
    req(1'b1, 1'b0, 4'b1111, a7, 64'h0, c);
    push(K_RD, c, 1'b1, 64'h0, 4'b1111, a7, 64'h0);
    tick(5);
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    ld_model = 64'h0;
    tick(1);
    reset = 1'b0;
    tick(2);
    ctl_stub = 1'b0; ctl_k = 2;
    req(1'b1, 1'b0, 4'b1000, a8, 64'h0, c);
    push(K_RD, c, 1'b1, 64'h0, 4'b1000, a8, 64'h0);
    ld_model = {16'h5A5A, 48'h0};
    push(K_DONE, c + 4, 1'b1, ld_model, 4'h0, 64'h0, 64'h0);
    tick(8);

    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
